register_file_mp: RTL and testbench



---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/register_file_mp.sv | 82 ++++++++
 tb/tb_register_file_mp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int unsigned RF_DW    = 32;
  localparam int unsigned RF_AW    = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [RF_AW-1:0] regaddr_t;

  // Bundles one write port for callers; the register file itself takes flat vectors.
  typedef struct packed {
    logic             wen;
    regaddr_t         wsel;
    logic [RF_DW-1:0] wdat;
  } rf_wr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with reserve/writeback-clear priority and a registered population count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREG-1:0] clr_i,
  input  logic            rsv_en_i,
  input  logic [AW-1:0]   rsv_sel_i,
  output logic [NREG-1:0] busy_o,
  output logic [AW:0]     busy_cnt_o
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q & ~clr_i;
    // Reserve applied after the clear so a new producer outranks a same-cycle writeback.
    if (rsv_en_i && (rsv_sel_i != ZeroAddr)) begin
      busy_d[rsv_sel_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int k = 0; k < NREG; k++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[k]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with r0 hardwired to zero and a busy scoreboard.
// Optional same-cycle write-to-read forwarding when REGISTER_FILE_BYPASS_EN is defined.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NRD*AW-1:0] rsel,
  output logic [NRD*DW-1:0] rdat,
  output logic [NRD-1:0]    rbusy,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] wsel,
  input  logic [NWR*DW-1:0] wdat,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_sel,
  output logic [AW:0]       busy_cnt
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy;

  // Ascending port order makes the highest-index writer win on address collisions.
  always_comb begin
    regs_d  = regs_q;
    clr_vec = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && (wsel[j*AW +: AW] != ZeroAddr)) begin
        regs_d[wsel[j*AW +: AW]]  = wdat[j*DW +: DW];
        clr_vec[wsel[j*AW +: AW]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (clr_vec),
    .rsv_en_i  (rsv_en),
    .rsv_sel_i (rsv_sel),
    .busy_o    (busy),
    .busy_cnt_o(busy_cnt)
  );

  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rdat[i*DW +: DW] = regs_q[rsel[i*AW +: AW]];
      rbusy[i]         = busy[rsel[i*AW +: AW]];
`ifdef REGISTER_FILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (wsel[j*AW +: AW] == rsel[i*AW +: AW]) &&
            (rsel[i*AW +: AW] != ZeroAddr)) begin
          rdat[i*DW +: DW] = wdat[j*DW +: DW];
          rbusy[i]         = rsv_en && (rsv_sel == rsel[i*AW +: AW]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vector table, corner sequences, random vs model.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic              CLK;
  logic              RST;
  logic [NRD*AW-1:0] rsel;
  logic [NRD*DW-1:0] rdat;
  logic [NRD-1:0]    rbusy;
  logic [NWR-1:0]    wen;
  logic [NWR*AW-1:0] wsel;
  logic [NWR*DW-1:0] wdat;
  logic              rsv_en;
  logic [AW-1:0]     rsv_sel;
  logic [AW:0]       busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_mp #(
    .DW  (DW),
    .NREG(NREG),
    .NRD (NRD),
    .NWR (NWR)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .rsel    (rsel),
    .rdat    (rdat),
    .rbusy   (rbusy),
    .wen     (wen),
    .wsel    (wsel),
    .wdat    (wdat),
    .rsv_en  (rsv_en),
    .rsv_sel (rsv_sel),
    .busy_cnt(busy_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: architectural register values and busy flags.
  logic [DW-1:0] m_mem  [NREG];
  bit            m_busy [NREG];

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < NREG; k++) c += int'(m_busy[k]);
    return c;
  endfunction

  task automatic model_update();
    if (RST) begin
      for (int k = 0; k < NREG; k++) begin
        m_mem[k]  = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && wsel[j*AW +: AW] != 0) begin
          m_mem[wsel[j*AW +: AW]]  = wdat[j*DW +: DW];
          m_busy[wsel[j*AW +: AW]] = 1'b0;
        end
      end
      if (rsv_en && rsv_sel != 0) m_busy[rsv_sel] = 1'b1;
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
    d = (a == 0) ? '0 : m_mem[a];
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGISTER_FILE_BYPASS_EN
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && wsel[j*AW +: AW] == a && a != 0) begin
        d = wdat[j*DW +: DW];
        b = rsv_en && (rsv_sel == a);
      end
    end
`endif
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] d;
    logic          b;
    for (int i = 0; i < NRD; i++) begin
      model_read(rsel[i*AW +: AW], d, b);
      check($sformatf("%s rdat%0d", tag, i), 64'(rdat[i*DW +: DW]), 64'(d));
      check($sformatf("%s rbusy%0d", tag, i), 64'(rbusy[i]), 64'(b));
    end
    check($sformatf("%s busy_cnt", tag), 64'(busy_cnt), 64'(m_count()));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; wen = '0; rsv_en = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic [1:0]    wen;
    logic [AW-1:0] wsel0, wsel1;
    logic [DW-1:0] wdat0, wdat1;
    logic          rsv_en;
    logic [AW-1:0] rsv_sel;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_dat;
    logic          exp_busy;
    logic [AW:0]   exp_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Row applied for one edge; outputs then checked with controls idle and rsel = ra.
    vecs[0] = '{1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 6'd0};
    vecs[1] = '{1'b1, 2'b01, 5'd5, 5'd0, 32'h12345678, 32'h0, 1'b1, 5'd5, 5'd5, 32'h0, 1'b0, 6'd0};
    vecs[2] = '{1'b0, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 6'd0};
    vecs[3] = '{1'b0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 32'h22, 1'b0, 6'd0};
    vecs[4] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 32'h0, 1'b1, 6'd1};
    vecs[5] = '{1'b0, 2'b01, 5'd3, 5'd0, 32'h1234, 32'h0, 1'b0, 5'd0, 5'd3, 32'h1234, 1'b0, 6'd0};
    vecs[6] = '{1'b0, 2'b01, 5'd3, 5'd0, 32'h5678, 32'h0, 1'b1, 5'd3, 5'd3, 32'h5678, 1'b1, 6'd1};
    vecs[7] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 32'h5678, 1'b1, 6'd1};
    vecs[8] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 6'd1};
    vecs[9] = '{1'b0, 2'b10, 5'd0, 5'd3, 32'h0, 32'h9ABC, 1'b0, 5'd0, 5'd3, 32'h9ABC, 1'b0, 6'd0};

    RST = 1'b1; wen = '0; wsel = '0; wdat = '0; rsv_en = 1'b0; rsv_sel = '0; rsel = '0;
    tick();
    tick();
    idle();
    rsel = {5'd5, 5'd1};
    #1;
    check_model("reset");

    for (int v = 0; v < 10; v++) begin
      RST = vecs[v].rst; wen = vecs[v].wen;
      wsel = {vecs[v].wsel1, vecs[v].wsel0};
      wdat = {vecs[v].wdat1, vecs[v].wdat0};
      rsv_en = vecs[v].rsv_en; rsv_sel = vecs[v].rsv_sel;
      rsel = {vecs[v].ra, vecs[v].ra};
      tick();
      idle();
      #1;
      check($sformatf("vec%0d rdat0", v), 64'(rdat[31:0]), 64'(vecs[v].exp_dat));
      check($sformatf("vec%0d rdat1", v), 64'(rdat[63:32]), 64'(vecs[v].exp_dat));
      check($sformatf("vec%0d rbusy0", v), 64'(rbusy[0]), 64'(vecs[v].exp_busy));
      check($sformatf("vec%0d busy_cnt", v), 64'(busy_cnt), 64'(vecs[v].exp_cnt));
    end

    // Write r9 while reading it: forwarded only when bypass is built in.
    rsel = {5'd9, 5'd9};
    wen = 2'b01; wsel = {5'd0, 5'd9}; wdat = {32'h0, 32'h0000CAFE};
    #1;
`ifdef REGISTER_FILE_BYPASS_EN
    check("bypass same-cycle", 64'(rdat[31:0]), 64'h0000CAFE);
`else
    check("no-bypass same-cycle", 64'(rdat[31:0]), 64'h0);
`endif
    tick();
    idle();
    #1;
    check("bypass next-cycle", 64'(rdat[31:0]), 64'h0000CAFE);

    // Fill the scoreboard.
    RST = 1'b1;
    tick();
    idle();
    for (int k = 1; k < NREG; k++) begin
      rsv_en = 1'b1; rsv_sel = AW'(k);
      tick();
      rsv_en = 1'b0;
      #1;
      if (k == 16) check("fill half busy_cnt", 64'(busy_cnt), 64'd16);
    end
    check("fill busy_cnt", 64'(busy_cnt), 64'd31);
    rsel = {5'd31, 5'd1};
    #1;
    check("fill rbusy r1", 64'(rbusy[0]), 64'd1);
    check("fill rbusy r31", 64'(rbusy[1]), 64'd1);
    rsv_en = 1'b1; rsv_sel = 5'd1;
    tick();
    rsv_en = 1'b0;
    #1;
    check("re-reserve busy_cnt", 64'(busy_cnt), 64'd31);

    // Randomised traffic against the model; small addresses weighted to force collisions.
    for (int c = 0; c < 500; c++) begin
      RST = ($urandom_range(59, 0) == 0);
      for (int j = 0; j < NWR; j++) begin
        wen[j] = $urandom_range(1, 0) == 1;
        wsel[j*AW +: AW] = ($urandom_range(3, 0) == 0) ? AW'($urandom_range(7, 0))
                                                        : AW'($urandom_range(31, 0));
        wdat[j*DW +: DW] = $urandom;
      end
      rsv_en = $urandom_range(2, 0) != 0;
      rsv_sel = ($urandom_range(1, 0) == 0) ? wsel[AW-1:0] : AW'($urandom_range(31, 0));
      for (int i = 0; i < NRD; i++) begin
        rsel[i*AW +: AW] = ($urandom_range(1, 0) == 0) ? wsel[AW-1:0]
                                                        : AW'($urandom_range(31, 0));
      end
      #1;
      check_model($sformatf("rand%0d", c));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
